fractional_sub_serial: RTL and testbench

- Multi-cycle fixed-point subtractor: Out = A - B on two's-complement Q7.8 operands (DATA_WIDTH=16 default).
- Processes BITS_PER_CYCLE bits per clock through a ripple-borrow chain, LSB slice first.
- Sits beside the combinational fractional adder in the Execution stage; serves area-constrained lanes where subtraction may take several cycles.
- Valid/ready handshake on both input and output sides.

---
 rtl/frac_pkg.sv | 26 ++
 rtl/fractional_sub_serial_if.sv | 31 +++
 rtl/fractional_sub_slice.sv | 30 +++
 rtl/fractional_sub_serial.sv | 141 ++++++++++++++
 tb/tb_fractional_sub_serial.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/frac_pkg.sv
// frac_pkg: shared types and constants for the fractional arithmetic lanes.
//   DATA_WIDTH_DEF : default operand width (Q7.8 when 16)
//   FRAC_BITS      : fractional bits of the Q format
//   max_pos/min_neg: most positive / most negative two's-complement value
//                    for a given width (returned in 64 bits, caller truncates)
//   state_t        : sequencer states of the serial subtractor
package frac_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS      = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [63:0] max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fractional_sub_serial_if.sv
// fractional_sub_serial_if: operand/result handshake bundle.
//   in_valid/in_ready   : operand handshake, A (minuend) and B (subtrahend)
//   out_valid/out_ready : result handshake, Out = A - B
//   borrow_out          : unsigned A < B
//   overflow            : signed overflow of A - B
// master: operand source / result consumer; slave: the subtractor.
interface fractional_sub_serial_if import frac_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Out;
  logic                  borrow_out;
  logic                  overflow;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Out, borrow_out, overflow
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Out, borrow_out, overflow
  );

endinterface

// File: rtl/fractional_sub_slice.sv
// fractional_sub_slice: combinational WIDTH-bit ripple-borrow subtractor slice.
//   a, b       : slice of minuend / subtrahend
//   borrow_in  : borrow from the next-lower slice
//   diff       : a - b - borrow_in (WIDTH bits)
//   borrow_out : borrow into the next-higher slice
module fractional_sub_slice #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  always_comb begin
    logic bw;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned (which would infer a latch); blocking '=' is required here
    // because each bit's borrow feeds the next iteration in the same pass.
    diff = '0;
    bw   = borrow_in;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ b[i] ^ bw;
      bw      = (~a[i] & b[i]) | (~a[i] & bw) | (b[i] & bw);
    end
    borrow_out = bw;
  end

endmodule

// File: rtl/fractional_sub_serial.sv
// fractional_sub_serial: multi-cycle two's-complement subtractor, Out = A - B.
// Resolves BITS_PER_CYCLE bits per clock, LSB slice first, through one shared
// borrow-chain slice; result valid DATA_WIDTH/BITS_PER_CYCLE cycles after accept.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fractional_sub_serial_if.slave (operand and result handshakes)
// Build option: define FRACTIONAL_SUB_SAT_EN to saturate Out on signed overflow
// (MAX_POS when A is non-negative, MIN_NEG otherwise); default wraps.
module fractional_sub_serial import frac_pkg::*; #(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                    clk,
  input logic                    rst,
  fractional_sub_serial_if.slave bus
);

  localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = DATA_WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((BITS_PER_CYCLE < 1) || (DATA_WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_cfg
    $error("BITS_PER_CYCLE must be >= 1 and divide DATA_WIDTH");
  end

`ifdef FRACTIONAL_SUB_SAT_EN
  localparam logic [DATA_WIDTH-1:0] MAX_POS_C = DATA_WIDTH'(max_pos(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] MIN_NEG_C = DATA_WIDTH'(min_neg(DATA_WIDTH));
`endif

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    bw_q;
  logic                    borrow_q;
  logic                    ovf_q;
  logic                    ovf_d;
  logic                    load, step, last;
  logic                    in_ready, out_valid;
  int                      base;
  logic [BITS_PER_CYCLE-1:0] a_sl, b_sl, d_sl;
  logic                    bw_sl;

  // Current slice of the latched operands, selected by the slice counter.
  assign base = int'(cnt_q) * BITS_PER_CYCLE;
  assign a_sl = a_q[base +: BITS_PER_CYCLE];
  assign b_sl = b_q[base +: BITS_PER_CYCLE];
  assign last = (cnt_q == LAST);

  fractional_sub_slice #(
    .WIDTH(BITS_PER_CYCLE)
  ) u_slice (
    .a         (a_sl),
    .b         (b_sl),
    .borrow_in (bw_q),
    .diff      (d_sl),
    .borrow_out(bw_sl)
  );

  // Result with the slice being resolved this cycle merged in; on the final
  // slice this is the complete raw difference used for the overflow flag.
  always_comb begin
    res_d = res_q;
    res_d[base +: BITS_PER_CYCLE] = d_sl;
    ovf_d = (a_q[MSB] != b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
  end

  // Sequencer: IDLE accepts, RUN steps N slices, DONE holds until consumed.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the operand registers are plain flops, not a memory, so clearing
  // them on reset is cheap and keeps a discarded operation from lingering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      a_q      <= bus.A;
      b_q      <= bus.B;
      res_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (step) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      bw_q  <= bw_sl;
      res_q <= res_d;
      if (last) begin
        borrow_q <= bw_sl;
        ovf_q    <= ovf_d;
`ifdef FRACTIONAL_SUB_SAT_EN
        // Clamp toward the sign of the minuend; the borrow flag stays raw.
        if (ovf_d) res_q <= a_q[MSB] ? MIN_NEG_C : MAX_POS_C;
`endif
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.Out        = res_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_fractional_sub_serial.sv
// Bench for fractional_sub_serial: a 1-bit/cycle instance (dut1) and a
// 4-bit/cycle instance (dut4) share clk/rst. Drivers push expected results
// into per-instance queues; a monitor pops and compares on each result
// handshake and checks accept-to-valid latency.
module tb_fractional_sub_serial;

  localparam bit SAT = `ifdef FRACTIONAL_SUB_SAT_EN 1'b1 `else 1'b0 `endif ;

  typedef struct {
    logic [15:0] out;
    logic        bw;
    logic        ov;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic        bw;
    logic        ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   seen1 = 1'b0;
  bit   seen4 = 1'b0;
  exp_t q1[$];
  exp_t q4[$];

  fractional_sub_serial_if #(.DATA_WIDTH(16)) if1 ();
  fractional_sub_serial_if #(.DATA_WIDTH(16)) if4 ();

  fractional_sub_serial #(.DATA_WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  fractional_sub_serial #(.DATA_WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sat_or(input logic [15:0] raw, input logic [15:0] sat);
    return SAT ? sat : raw;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out or unexpected event (t=%0t)", name, $time);
  endtask

  function automatic logic rdy(input int which);
    return (which == 1) ? if1.in_ready : if4.in_ready;
  endfunction

  // Called at a negedge. Presents operands, waits for in_ready, records the
  // accepting edge. Returns at the negedge after that edge.
  task automatic issue(input int which, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eo, input logic ebw, input logic eov,
                       input bit push, input bit hold, output int acc);
    int   budget;
    exp_t e;
    if (which == 1) begin if1.in_valid = 1'b1; if1.A = a; if1.B = b; end
    else            begin if4.in_valid = 1'b1; if4.A = a; if4.B = b; end
    budget = 0;
    while (!rdy(which) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) fail_now("accept_timeout");
    acc = cyc + 1;
    if (push) begin
      e.out = eo; e.bw = ebw; e.ov = eov; e.acc = acc;
      if (which == 1) q1.push_back(e); else q4.push_back(e);
    end
    @(negedge clk);
    if (!hold) begin
      if (which == 1) if1.in_valid = 1'b0; else if4.in_valid = 1'b0;
    end
  endtask

  // Monitor: sampled 1 time unit after the falling edge.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst) begin
      seen1 = 1'b0;
      seen4 = 1'b0;
    end else begin
      if (if1.out_valid && !seen1) begin
        seen1 = 1'b1;
        if (q1.size() == 0) fail_now("dut1_unexpected_output");
        else check("dut1_latency", cyc - q1[0].acc, 16);
      end
      if (if1.out_valid && if1.out_ready) begin
        seen1 = 1'b0;
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("dut1_out", {16'h0, if1.Out}, {16'h0, e.out});
          check("dut1_borrow", {31'h0, if1.borrow_out}, {31'h0, e.bw});
          check("dut1_overflow", {31'h0, if1.overflow}, {31'h0, e.ov});
        end
      end
      if (if4.out_valid && !seen4) begin
        seen4 = 1'b1;
        if (q4.size() == 0) fail_now("dut4_unexpected_output");
        else check("dut4_latency", cyc - q4[0].acc, 4);
      end
      if (if4.out_valid && if4.out_ready) begin
        seen4 = 1'b0;
        if (q4.size() != 0) begin
          e = q4.pop_front();
          check("dut4_out", {16'h0, if4.Out}, {16'h0, e.out});
          check("dut4_borrow", {31'h0, if4.borrow_out}, {31'h0, e.bw});
          check("dut4_overflow", {31'h0, if4.overflow}, {31'h0, e.ov});
        end
      end
    end
  end

  initial begin
    vec_t vecs[8];
    int   acc, acc_a, acc_b, acc_c, budget;

    vecs[0] = '{16'h0300, 16'h0180, 16'h0180, 1'b0, 1'b0};
    vecs[1] = '{16'h0080, 16'h0100, 16'hFF80, 1'b1, 1'b0};
    vecs[2] = '{16'h7F00, 16'h8100, sat_or(16'hFE00, 16'h7FFF), 1'b1, 1'b1};
    vecs[3] = '{16'h8100, 16'h7F00, sat_or(16'h0200, 16'h8000), 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h0001, sat_or(16'h7FFF, 16'h8000), 1'b0, 1'b1};

    if1.in_valid = 1'b0; if1.A = '0; if1.B = '0; if1.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.A = '0; if4.B = '0; if4.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", {31'h0, if1.in_ready}, 1);
    check("rst_out_valid", {31'h0, if1.out_valid}, 0);
    check("rst_out", {16'h0, if1.Out}, 0);
    check("rst_borrow", {31'h0, if1.borrow_out}, 0);
    check("rst_overflow", {31'h0, if1.overflow}, 0);
    check("rst4_in_ready", {31'h0, if4.in_ready}, 1);
    check("rst4_out_valid", {31'h0, if4.out_valid}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on the bit-serial instance.
    foreach (vecs[i])
      issue(1, vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].bw, vecs[i].ov, 1'b1, 1'b0, acc);

    budget = 0;
    while (q1.size() != 0 && budget < 100) begin @(negedge clk); budget++; end
    if (budget >= 100) fail_now("drain_before_backpressure");

    // Backpressure: result must hold in DONE, in_valid pulses ignored.
    if1.out_ready = 1'b0;
    issue(1, 16'h4000, 16'h0001, 16'h3FFF, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    budget = 0;
    while (!if1.out_valid && budget < 40) begin @(negedge clk); budget++; end
    if (budget >= 40) fail_now("bp_wait_valid");
    for (int k = 0; k < 5; k++) begin
      if1.in_valid = (k % 2 == 0);
      if1.A = 16'h1111 + 16'(k);
      if1.B = 16'h2222;
      #1;
      check("bp_out_valid", {31'h0, if1.out_valid}, 1);
      check("bp_in_ready", {31'h0, if1.in_ready}, 0);
      check("bp_out", {16'h0, if1.Out}, 32'h3FFF);
      check("bp_flags", {30'h0, if1.borrow_out, if1.overflow}, 0);
      @(negedge clk);
    end
    if1.in_valid = 1'b0;
    if1.out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_valid", {31'h0, if1.out_valid}, 0);
    check("bp_release_ready", {31'h0, if1.in_ready}, 1);
    @(negedge clk);

    // Reset mid-run: abort after slice 7, then a fresh operation.
    issue(1, 16'h0300, 16'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'h0, if1.out_valid}, 0);
    check("midrst_in_ready", {31'h0, if1.in_ready}, 1);
    check("midrst_out", {16'h0, if1.Out}, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(1, 16'h0200, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, acc);

    // 4 bits per cycle, back-to-back with in_valid held.
    issue(4, 16'h1234, 16'h0235, 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b1, acc_a);
    issue(4, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, acc_b);
    issue(4, 16'h7FFF, 16'hFFFF, sat_or(16'h8000, 16'h7FFF), 1'b1, 1'b1, 1'b1, 1'b0, acc_c);
    check("b2b_spacing_1", acc_b - acc_a, 6);
    check("b2b_spacing_2", acc_c - acc_b, 6);

    budget = 0;
    while ((q1.size() != 0 || q4.size() != 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) fail_now("final_drain");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
